// File: rtl/decode_stage_pkg.sv
// Shared Y86-64 definitions for the decode/write-back stage:
// widths, register IDs, instruction codes and status codes.
package decode_stage_pkg;

  localparam int NIBBLE = 4;
  localparam int D_WORD = 64;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB,
    ICODE_C = 4'hC,
    ICODE_D = 4'hD,
    ICODE_E = 4'hE,
    ICODE_F = 4'hF
  } icode_e;

  localparam logic [3:0] SBUB = 4'h0;
  localparam logic [3:0] SAOK = 4'h1;
  localparam logic [3:0] SADR = 4'h2;
  localparam logic [3:0] SINS = 4'h3;
  localparam logic [3:0] SHLT = 4'h4;

  // A source ID forwards from a destination only when both name a real register.
  function automatic logic id_match(input logic [3:0] src, input logic [3:0] dst);
    return (src != RNONE) && (src == dst);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Bundle of D-stage fields, forwarding sources, write-back ports and the
// E pipeline register outputs. The slave side is the decode stage.
interface decode_stage_if;
  logic [3:0]  D_stat_i, D_icode_i, D_ifun_i, D_rA_i, D_rB_i;
  logic [63:0] D_valC_i, D_valP_i;
  logic [3:0]  e_dstE_i;
  logic [63:0] e_valE_i;
  logic [3:0]  M_dstE_i, M_dstM_i;
  logic [63:0] M_valE_i, m_valM_i;
  logic [3:0]  W_dstE_i, W_dstM_i;
  logic [63:0] W_valE_i, W_valM_i;
  logic        E_bubble_i;
  logic [3:0]  d_srcA_o, d_srcB_o;
  logic [3:0]  E_stat_o, E_icode_o, E_ifun_o;
  logic [63:0] E_valC_o, E_valA_o, E_valB_o;
  logic [3:0]  E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o;

  modport slave (
    input  D_stat_i, D_icode_i, D_ifun_i, D_rA_i, D_rB_i, D_valC_i, D_valP_i,
    input  e_dstE_i, e_valE_i, M_dstE_i, M_dstM_i, M_valE_i, m_valM_i,
    input  W_dstE_i, W_dstM_i, W_valE_i, W_valM_i, E_bubble_i,
    output d_srcA_o, d_srcB_o, E_stat_o, E_icode_o, E_ifun_o,
    output E_valC_o, E_valA_o, E_valB_o, E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o
  );

  modport master (
    output D_stat_i, D_icode_i, D_ifun_i, D_rA_i, D_rB_i, D_valC_i, D_valP_i,
    output e_dstE_i, e_valE_i, M_dstE_i, M_dstM_i, M_valE_i, m_valM_i,
    output W_dstE_i, W_dstM_i, W_valE_i, W_valM_i, E_bubble_i,
    input  d_srcA_o, d_srcB_o, E_stat_o, E_icode_o, E_ifun_o,
    input  E_valC_o, E_valA_o, E_valB_o, E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o
  );
endinterface

// File: rtl/decode_stage_regfile.sv
// Y86-64 register file: two combinational read ports, two write ports.
// When both write ports hit the same register the dstM port wins.
module decode_stage_regfile
  import decode_stage_pkg::*;
#(
  parameter int          NREG      = 15,
  parameter logic [63:0] RESET_VAL = 64'h0
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [3:0]  i_srcA,
  input  logic [3:0]  i_srcB,
  output logic [63:0] o_valA,
  output logic [63:0] o_valB,
  input  logic [3:0]  i_dstE,
  input  logic [63:0] i_valE,
  input  logic [3:0]  i_dstM,
  input  logic [63:0] i_valM
);

  logic [63:0] r_regs [NREG];

  // Write both ports on the clock edge; the dstM write is last so it takes priority.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= RESET_VAL;
    end else begin
      if ((i_dstE != RNONE) && (32'(i_dstE) < NREG)) r_regs[i_dstE] <= i_valE;
      if ((i_dstM != RNONE) && (32'(i_dstM) < NREG)) r_regs[i_dstM] <= i_valM;
    end
  end

  // Combinational reads; RNONE (or any out-of-range ID) reads as zero.
  always_comb begin
    if ((i_srcA != RNONE) && (32'(i_srcA) < NREG)) o_valA = r_regs[i_srcA];
    else                                            o_valA = 64'h0;
    if ((i_srcB != RNONE) && (32'(i_srcB) < NREG)) o_valB = r_regs[i_srcB];
    else                                            o_valB = 64'h0;
  end

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode/write-back stage: register ID decode, register file access,
// forwarding from e/M/W, and the E pipeline register feeding execute.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int          NREG      = 15,
  parameter logic [63:0] RESET_VAL = 64'h0
) (
  input logic           clk_i,
  input logic           rstn_i,
  decode_stage_if.slave bus
);

  icode_e      w_icode;
  logic [3:0]  w_srcA, w_srcB, w_dstE, w_dstM;
  logic [63:0] w_rf_valA, w_rf_valB, w_valA, w_valB;

  logic [3:0]  r_E_stat, r_E_icode, r_E_ifun, r_E_dstE, r_E_dstM, r_E_srcA, r_E_srcB;
  logic [63:0] r_E_valC, r_E_valA, r_E_valB;

  assign w_icode = icode_e'(bus.D_icode_i);

  decode_stage_regfile #(.NREG(NREG), .RESET_VAL(RESET_VAL)) u_regfile (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .i_srcA (w_srcA),
    .i_srcB (w_srcB),
    .o_valA (w_rf_valA),
    .o_valB (w_rf_valB),
    .i_dstE (bus.W_dstE_i),
    .i_valE (bus.W_valE_i),
    .i_dstM (bus.W_dstM_i),
    .i_valM (bus.W_valM_i)
  );

  // Decode source and destination register IDs from the instruction code.
  always_comb begin
    w_srcA = RNONE;
    w_srcB = RNONE;
    w_dstE = RNONE;
    w_dstM = RNONE;
    case (w_icode)
      IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: w_srcA = bus.D_rA_i;
      IPOPQ, IRET:                    w_srcA = RSP;
      default:                        w_srcA = RNONE;
    endcase
    case (w_icode)
      IOPQ, IRMMOVQ, IMRMOVQ:         w_srcB = bus.D_rB_i;
      IPUSHQ, IPOPQ, ICALL, IRET:     w_srcB = RSP;
      default:                        w_srcB = RNONE;
    endcase
    case (w_icode)
      IRRMOVQ, IIRMOVQ, IOPQ:         w_dstE = bus.D_rB_i;
      IPUSHQ, IPOPQ, ICALL, IRET:     w_dstE = RSP;
      default:                        w_dstE = RNONE;
    endcase
    case (w_icode)
      IMRMOVQ, IPOPQ:                 w_dstM = bus.D_rA_i;
      default:                        w_dstM = RNONE;
    endcase
  end

  // Forwarding select: nearest pipeline stage wins, register file is the fallback.
  always_comb begin
    if ((w_icode == ICALL) || (w_icode == IJXX)) w_valA = bus.D_valP_i;
    else if (id_match(w_srcA, bus.e_dstE_i))     w_valA = bus.e_valE_i;
    else if (id_match(w_srcA, bus.M_dstM_i))     w_valA = bus.m_valM_i;
    else if (id_match(w_srcA, bus.M_dstE_i))     w_valA = bus.M_valE_i;
    else if (id_match(w_srcA, bus.W_dstM_i))     w_valA = bus.W_valM_i;
    else if (id_match(w_srcA, bus.W_dstE_i))     w_valA = bus.W_valE_i;
    else                                         w_valA = w_rf_valA;

    if (id_match(w_srcB, bus.e_dstE_i))          w_valB = bus.e_valE_i;
    else if (id_match(w_srcB, bus.M_dstM_i))     w_valB = bus.m_valM_i;
    else if (id_match(w_srcB, bus.M_dstE_i))     w_valB = bus.M_valE_i;
    else if (id_match(w_srcB, bus.W_dstM_i))     w_valB = bus.W_valM_i;
    else if (id_match(w_srcB, bus.W_dstE_i))     w_valB = bus.W_valE_i;
    else                                         w_valB = w_rf_valB;
  end

  // E pipeline register: bubble on reset or request, otherwise capture decoded D.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i || bus.E_bubble_i) begin
      r_E_stat  <= SBUB;
      r_E_icode <= INOP;
      r_E_ifun  <= 4'h0;
      r_E_valC  <= 64'h0;
      r_E_valA  <= 64'h0;
      r_E_valB  <= 64'h0;
      r_E_dstE  <= RNONE;
      r_E_dstM  <= RNONE;
      r_E_srcA  <= RNONE;
      r_E_srcB  <= RNONE;
    end else begin
      r_E_stat  <= bus.D_stat_i;
      r_E_icode <= bus.D_icode_i;
      r_E_ifun  <= bus.D_ifun_i;
      r_E_valC  <= bus.D_valC_i;
      r_E_valA  <= w_valA;
      r_E_valB  <= w_valB;
      r_E_dstE  <= w_dstE;
      r_E_dstM  <= w_dstM;
      r_E_srcA  <= w_srcA;
      r_E_srcB  <= w_srcB;
    end
  end

  assign bus.d_srcA_o  = w_srcA;
  assign bus.d_srcB_o  = w_srcB;
  assign bus.E_stat_o  = r_E_stat;
  assign bus.E_icode_o = r_E_icode;
  assign bus.E_ifun_o  = r_E_ifun;
  assign bus.E_valC_o  = r_E_valC;
  assign bus.E_valA_o  = r_E_valA;
  assign bus.E_valB_o  = r_E_valB;
  assign bus.E_dstE_o  = r_E_dstE;
  assign bus.E_dstM_o  = r_E_dstM;
  assign bus.E_srcA_o  = r_E_srcA;
  assign bus.E_srcB_o  = r_E_srcB;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage with a behavioural reference model,
// a per-cycle compare process and directed literal checks.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  always #5 clk_i = ~clk_i;

  decode_stage_if intf ();

  decode_stage #(.NREG(15), .RESET_VAL(64'h0)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (intf)
  );

  int checks = 0;
  int errors = 0;

  // Model state: architectural registers and the expected E register.
  logic [63:0] m_regs [15];
  logic        exp_valid = 1'b0;
  logic [3:0]  exp_stat, exp_icode, exp_ifun, exp_dstE, exp_dstM, exp_srcA, exp_srcB;
  logic [63:0] exp_valC, exp_valA, exp_valB;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle the E register must match the model.
  always @(negedge clk_i) begin
    if (exp_valid) begin
      chk("E_stat",  {60'h0, intf.E_stat_o},  {60'h0, exp_stat});
      chk("E_icode", {60'h0, intf.E_icode_o}, {60'h0, exp_icode});
      chk("E_ifun",  {60'h0, intf.E_ifun_o},  {60'h0, exp_ifun});
      chk("E_valC",  intf.E_valC_o, exp_valC);
      chk("E_valA",  intf.E_valA_o, exp_valA);
      chk("E_valB",  intf.E_valB_o, exp_valB);
      chk("E_dstE",  {60'h0, intf.E_dstE_o},  {60'h0, exp_dstE});
      chk("E_dstM",  {60'h0, intf.E_dstM_o},  {60'h0, exp_dstM});
      chk("E_srcA",  {60'h0, intf.E_srcA_o},  {60'h0, exp_srcA});
      chk("E_srcB",  {60'h0, intf.E_srcB_o},  {60'h0, exp_srcB});
    end
  end

  task automatic set_exp_bubble();
    exp_stat = SBUB; exp_icode = 4'h1; exp_ifun = 4'h0;
    exp_valC = 64'h0; exp_valA = 64'h0; exp_valB = 64'h0;
    exp_dstE = 4'hF; exp_dstM = 4'hF; exp_srcA = 4'hF; exp_srcB = 4'hF;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_regs[i] = 64'h0;
    set_exp_bubble();
  endtask

  // Value a source register holds this cycle: the youngest in-flight writer,
  // else the architectural register, with RNONE reading as zero.
  function automatic logic [63:0] model_read(input logic [3:0] s);
    logic [3:0]  d [5];
    logic [63:0] v [5];
    d = '{intf.e_dstE_i, intf.M_dstM_i, intf.M_dstE_i, intf.W_dstM_i, intf.W_dstE_i};
    v = '{intf.e_valE_i, intf.m_valM_i, intf.M_valE_i, intf.W_valM_i, intf.W_valE_i};
    if (s == 4'hF) return 64'h0;
    for (int i = 0; i < 5; i++) if (d[i] == s) return v[i];
    return m_regs[s];
  endfunction

  // One clock: check comb source IDs, predict E, advance the edge, commit write-back.
  task automatic cycle();
    logic [3:0]  ic, sA, sB, dE, dM;
    logic [63:0] vA, vB;
    #1;
    ic = intf.D_icode_i;
    sA = 4'hF; sB = 4'hF; dE = 4'hF; dM = 4'hF;
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) sA = intf.D_rA_i;
    if (ic inside {4'hB, 4'h9})             sA = 4'h4;
    if (ic inside {4'h6, 4'h4, 4'h5})       sB = intf.D_rB_i;
    if (ic inside {4'hA, 4'hB, 4'h8, 4'h9}) sB = 4'h4;
    if (ic inside {4'h2, 4'h3, 4'h6})       dE = intf.D_rB_i;
    if (ic inside {4'hA, 4'hB, 4'h8, 4'h9}) dE = 4'h4;
    if (ic inside {4'h5, 4'hB})             dM = intf.D_rA_i;
    vA = (ic inside {4'h8, 4'h7}) ? intf.D_valP_i : model_read(sA);
    vB = model_read(sB);
    chk("d_srcA", {60'h0, intf.d_srcA_o}, {60'h0, sA});
    chk("d_srcB", {60'h0, intf.d_srcB_o}, {60'h0, sB});
    @(posedge clk_i);
    if (intf.W_dstE_i != 4'hF) m_regs[intf.W_dstE_i] = intf.W_valE_i;
    if (intf.W_dstM_i != 4'hF) m_regs[intf.W_dstM_i] = intf.W_valM_i;
    if (intf.E_bubble_i) begin
      set_exp_bubble();
    end else begin
      exp_stat = intf.D_stat_i; exp_icode = ic; exp_ifun = intf.D_ifun_i;
      exp_valC = intf.D_valC_i; exp_valA = vA; exp_valB = vB;
      exp_dstE = dE; exp_dstM = dM; exp_srcA = sA; exp_srcB = sB;
    end
    exp_valid = 1'b1;
    @(negedge clk_i);
    #1;
  endtask

  task automatic set_idle();
    intf.D_stat_i = SAOK; intf.D_icode_i = 4'h1; intf.D_ifun_i = 4'h0;
    intf.D_rA_i = 4'hF; intf.D_rB_i = 4'hF;
    intf.D_valC_i = {$urandom, $urandom}; intf.D_valP_i = {$urandom, $urandom};
    intf.e_dstE_i = 4'hF; intf.M_dstE_i = 4'hF; intf.M_dstM_i = 4'hF;
    intf.W_dstE_i = 4'hF; intf.W_dstM_i = 4'hF;
    intf.e_valE_i = {$urandom, $urandom}; intf.M_valE_i = {$urandom, $urandom};
    intf.m_valM_i = {$urandom, $urandom}; intf.W_valE_i = {$urandom, $urandom};
    intf.W_valM_i = {$urandom, $urandom};
    intf.E_bubble_i = 1'b0;
  endtask

  function automatic logic [3:0] rand_id();
    return ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 14));
  endfunction

  task automatic set_random();
    set_idle();
    intf.D_stat_i  = 4'($urandom_range(0, 4));
    intf.D_icode_i = 4'($urandom_range(0, 15));
    intf.D_ifun_i  = 4'($urandom_range(0, 15));
    intf.D_rA_i = rand_id(); intf.D_rB_i = rand_id();
    intf.e_dstE_i = rand_id(); intf.M_dstE_i = rand_id(); intf.M_dstM_i = rand_id();
    intf.W_dstE_i = rand_id(); intf.W_dstM_i = rand_id();
    if ($urandom_range(0, 3) == 0) intf.W_dstM_i = intf.W_dstE_i;
    intf.E_bubble_i = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    set_idle();
    model_reset();
    exp_valid = 1'b1;
    rstn_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_icode", {60'h0, intf.E_icode_o}, 64'h1);
    chk("rst_stat",  {60'h0, intf.E_stat_o},  64'h0);
    chk("rst_dstE",  {60'h0, intf.E_dstE_o},  64'hF);
    chk("rst_srcB",  {60'h0, intf.E_srcB_o},  64'hF);
    rstn_i = 1'b1;

    // Every register reads zero after reset.
    for (int i = 0; i < 15; i++) begin
      set_idle(); intf.D_icode_i = 4'h6; intf.D_rA_i = 4'(i); intf.D_rB_i = 4'(14 - i);
      cycle();
      chk("rst_reg_A", intf.E_valA_o, 64'h0);
    end

    // Write-back then read back through both ports.
    set_idle(); intf.W_dstE_i = 4'h3; intf.W_valE_i = 64'h55; cycle();
    set_idle(); intf.D_icode_i = 4'h6; intf.D_rA_i = 4'h3; intf.D_rB_i = 4'h3; cycle();
    chk("wb_valA", intf.E_valA_o, 64'h55);
    chk("wb_valB", intf.E_valB_o, 64'h55);

    // Forwarding priority e > M > W.
    set_idle(); intf.D_icode_i = 4'h6; intf.D_rA_i = 4'h2; intf.D_rB_i = 4'h5;
    intf.e_dstE_i = 4'h2; intf.e_valE_i = 64'h11;
    intf.M_dstE_i = 4'h2; intf.M_valE_i = 64'h22;
    intf.W_dstE_i = 4'h2; intf.W_valE_i = 64'h33;
    cycle();
    chk("fwd_e", intf.E_valA_o, 64'h11);
    intf.e_dstE_i = 4'hF;
    cycle();
    chk("fwd_M", intf.E_valA_o, 64'h22);

    // popq %rsp: both write ports on RSP, memory value wins.
    set_idle(); intf.W_dstE_i = 4'h4; intf.W_dstM_i = 4'h4;
    intf.W_valE_i = 64'h100; intf.W_valM_i = 64'hABC; cycle();
    set_idle(); intf.D_icode_i = 4'h6; intf.D_rA_i = 4'h4; intf.D_rB_i = 4'h4; cycle();
    chk("popq_rsp", intf.E_valA_o, 64'hABC);

    // CALL: valA is valP regardless of forwarding; valB follows RSP.
    set_idle(); intf.D_icode_i = 4'h8; intf.D_valP_i = 64'h40; cycle();
    chk("call_valA", intf.E_valA_o, 64'h40);
    chk("call_valB", intf.E_valB_o, 64'hABC);
    intf.e_dstE_i = 4'h4; intf.e_valE_i = 64'h77; cycle();
    chk("call_fwd_valA", intf.E_valA_o, 64'h40);
    chk("call_fwd_valB", intf.E_valB_o, 64'h77);

    // Bubble during a valid OPQ, then normal load.
    set_idle(); intf.D_icode_i = 4'h6; intf.D_rA_i = 4'h1; intf.D_rB_i = 4'h2;
    intf.E_bubble_i = 1'b1; cycle();
    chk("bub_icode", {60'h0, intf.E_icode_o}, 64'h1);
    chk("bub_dstE",  {60'h0, intf.E_dstE_o},  64'hF);
    intf.E_bubble_i = 1'b0; cycle();
    chk("unbub_icode", {60'h0, intf.E_icode_o}, 64'h6);
    chk("unbub_dstE",  {60'h0, intf.E_dstE_o},  64'h2);

    // Randomized traffic with a mid-stream asynchronous reset.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        rstn_i = 1'b0;
        #1;
        model_reset();
        chk("async_rst_icode", {60'h0, intf.E_icode_o}, 64'h1);
        chk("async_rst_stat",  {60'h0, intf.E_stat_o},  64'h0);
        @(negedge clk_i);
        #1;
        rstn_i = 1'b1;
      end
      set_random();
      cycle();
    end

    exp_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Y86-64 pipeline decode/write-back stage, upstream of the execute stage.
- Derives source and destination register IDs from the D-stage fields and reads the 15-entry register file.
- Resolves data hazards by forwarding from the execute (e_), memory (M_/m_) and write-back (W_) stages.
- Writes back W-stage results and holds the E pipeline register that feeds execute.

Parameters:
- NREG, 15, number of architectural registers (IDs 0..14; 4'hF = RNONE).
- RESET_VAL, 64'h0, reset value of every register-file entry.

Ports:
- clk_i  in  1  clock; rising-edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- D_stat_i, D_icode_i, D_ifun_i, D_rA_i, D_rB_i  in  4 each  D-register fields.
- D_valC_i, D_valP_i  in  64 each  constant word, next PC.
- e_dstE_i  in  4  execute-stage destination after Cnd gating.
- e_valE_i  in  64  execute-stage ALU result.
- M_dstE_i, M_dstM_i  in  4 each  M-register destinations.
- M_valE_i, m_valM_i  in  64 each  M-register valE, memory read data.
- W_dstE_i, W_dstM_i  in  4 each  W-register destinations; also the write-port addresses.
- W_valE_i, W_valM_i  in  64 each  W-register values; also the write data.
- E_bubble_i  in  1  inject bubble into the E register.
- d_srcA_o, d_srcB_o  out  4 each  combinational source IDs, for the hazard unit.
- E_stat_o, E_icode_o, E_ifun_o  out  4 each  E-register fields.
- E_valC_o, E_valA_o, E_valB_o  out  64 each  E-register fields.
- E_dstE_o, E_dstM_o, E_srcA_o, E_srcB_o  out  4 each  E-register fields.

Behaviour:
- srcA:
  - rA for RRMOVQ/CMOVQ, RMMOVQ, OPQ, PUSHQ.
  - RSP (4) for POPQ, RET.
  - else RNONE.
- srcB:
  - rB for OPQ, RMMOVQ, MRMOVQ.
  - RSP for PUSHQ, POPQ, CALL, RET.
  - else RNONE.
- dstE:
  - rB for RRMOVQ/CMOVQ, IRMOVQ, OPQ.
  - RSP for PUSHQ, POPQ, CALL, RET.
  - else RNONE.
- dstM: rA for MRMOVQ, POPQ; else RNONE.
- valA select, first match wins:
  - D_icode in {CALL, JXX} -> D_valP.
  - srcA==e_dstE -> e_valE.
  - ==M_dstM -> m_valM.
  - ==M_dstE -> M_valE.
  - ==W_dstM -> W_valM.
  - ==W_dstE -> W_valE.
  - else register-file read.
- valB select: same priority chain on srcB, without the valP term.
- RNONE never matches: source or destination 4'hF disables forwarding. A read of RNONE returns 0.
- Register file reads are combinational.
- Register file writes occur on the rising edge:
  - dstE port writes W_valE; dstM port writes W_valM.
  - Both ports addressing the same register: dstM wins (popq %rsp semantics).
  - Writes to RNONE are ignored.
  - No internal write-to-read bypass; same-cycle hazards are covered by the W_ forwarding terms.
- E register update on rising edge:
  - E_bubble_i=1 -> load bubble: stat SBUB, icode INOP, ifun 0, valC/valA/valB 0, dst/src RNONE.
  - else load the decoded D-stage values; stat = D_stat.
- Reset (asynchronous, active-low):
  - all register-file entries = RESET_VAL.
  - E register = bubble contents.
  - Deasserting reset mid-stream: the first rising edge after deassertion loads normally.
- Latency: D inputs appear on E outputs one cycle later. Forwarded values are combinational within the cycle.
- Width rules: all data 64-bit, no truncation. IDs 4-bit, compared as full nibbles.

Decomposition:
- Icode, RNONE, RSP, stat codes (including SBUB) and widths NIBBLE/D_WORD belong in the shared define.v.
- One sub-module: regfile (2 combinational read ports, 2 write ports, asynchronous reset, dstM priority).

Test Plan:
- Reset: hold rstn_i=0 -> E_icode_o=INOP, E_stat_o=SBUB, all dst/src=4'hF; all registers read 0.
- Write-back: W_dstE=3, W_valE=0x55 for one edge, then OPQ rA=3 rB=3 with no hazards -> next cycle E_valA_o=E_valB_o=0x55.
- Forward priority: srcA=2 with e_dstE=2 (valE=0x11), M_dstE=2 (0x22) and W_dstE=2 (0x33) -> E_valA_o=0x11. Remove e_dstE -> 0x22.
- popq %rsp write-back: W_dstE=W_dstM=4, W_valE=0x100, W_valM=0xABC -> register 4 reads 0xABC.
- CALL D_valP=0x40, with e_dstE=RNONE versus e_dstE=4 -> E_valA_o=0x40 in both cases; E_valB_o = RSP value or forwarded e_valE respectively.
- Bubble: E_bubble_i=1 during a valid OPQ -> E_icode_o=INOP, E_dstE_o=4'hF; deassert -> next instruction loads normally.
